// File: rtl/fifo_ctrl_pkg.sv
// Shared definitions for the FIFO control blocks.
//   fifo_ctrl_state_e : two-state arbiter FSM encoding (ST_IDLE, ST_GRANT)
//   BEAT_CNT_W        : width of the per-grant beat counter
package fifo_ctrl_pkg;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } fifo_ctrl_state_e;

   localparam int unsigned BEAT_CNT_W = 8;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker.
//   req_vec    : request vector, one bit per requester
//   last_grant : index granted most recently; search starts one above it
//   winner     : first requesting index found from last_grant+1 upward with wrap
//   any_req    : at least one request bit is set
module rr_picker #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_vec,
   input  logic [IDX_W-1:0]   last_grant,
   output logic [IDX_W-1:0]   winner,
   output logic               any_req
);

   always_comb begin
      int unsigned idx;
      logic        found;
      idx    = 0;
      found  = 1'b0;
      winner = '0;
      // Offset NUM_REQ wraps back to last_grant itself, so a lone requester re-wins.
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
         idx = (32'(last_grant) + k) % NUM_REQ;
         if (!found && req_vec[idx]) begin
            winner = idx[IDX_W-1:0];
            found  = 1'b1;
         end
      end
   end

   assign any_req = |req_vec;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter in front of an async FIFO write port.
//   wr_clk, wr_rst_n       : write-domain clock, async active-low reset
//   req_valid/data/last    : per-requester beat stream (data packed i*DATA_WIDTH)
//   req_ready              : per-requester accept, only the grant holder may see 1
//   fifo_full              : FIFO full flag; stalls the holder
//   fifo_wr_en/wr_data     : FIFO write port, data passed through combinationally
//   grant_id, busy         : current holder (0 when idle) and grant-held flag
// A grant is held until the holder's last beat or MAX_BURST beats are accepted.
module fifo_wr_arbiter
   import fifo_ctrl_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned MAX_BURST  = 16,
   localparam int unsigned IDX_W     = $clog2(NUM_REQ)
) (
   input  logic                          wr_clk,
   input  logic                          wr_rst_n,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   input  logic [NUM_REQ-1:0]            req_last,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic                          fifo_full,
   output logic                          fifo_wr_en,
   output logic [DATA_WIDTH-1:0]         fifo_wr_data,
   output logic [IDX_W-1:0]              grant_id,
   output logic                          busy
);

   localparam logic [BEAT_CNT_W:0] MAX_BURST_C = (BEAT_CNT_W + 1)'(MAX_BURST);

   fifo_ctrl_state_e        state_q, state_d;
   logic [IDX_W-1:0]        grant_q, grant_d;
   logic [IDX_W-1:0]        last_q, last_d;
   logic [BEAT_CNT_W-1:0]   cnt_q, cnt_d;

   logic [DATA_WIDTH-1:0]   req_data_arr [NUM_REQ];
   logic [IDX_W-1:0]        winner;
   logic                    any_req;
   logic                    accept;
   logic [BEAT_CNT_W:0]     cnt_inc;

   always_comb begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         req_data_arr[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   rr_picker #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr_picker (
      .req_vec    (req_valid),
      .last_grant (last_q),
      .winner     (winner),
      .any_req    (any_req)
   );

   assign accept  = (state_q == ST_GRANT) && req_valid[grant_q] && !fifo_full;
   // One extra bit so MAX_BURST = 256 is reachable with an 8-bit counter.
   assign cnt_inc = {1'b0, cnt_q} + 1'b1;

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         ST_IDLE: begin
            if (any_req) begin
               state_d = ST_GRANT;
               grant_d = winner;
            end
         end
         ST_GRANT: begin
            if (accept) begin
               cnt_d = cnt_inc[BEAT_CNT_W-1:0];
               if (req_last[grant_q] || (cnt_inc == MAX_BURST_C)) begin
                  state_d = ST_IDLE;
                  last_d  = grant_q;
                  grant_d = '0;
                  cnt_d   = '0;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      req_ready    = '0;
      fifo_wr_en   = 1'b0;
      fifo_wr_data = '0;
      if (state_q == ST_GRANT) begin
         req_ready[grant_q] = !fifo_full;
         fifo_wr_en         = req_valid[grant_q] && !fifo_full;
         fifo_wr_data       = req_data_arr[grant_q];
      end
   end

   assign grant_id = grant_q;
   assign busy     = (state_q == ST_GRANT);

   always_ff @(posedge wr_clk or negedge wr_rst_n) begin
      if (!wr_rst_n) begin
         state_q <= ST_IDLE;
         grant_q <= '0;
         last_q  <= IDX_W'(NUM_REQ - 1);
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter with an in-bench behavioural model.
module tb_fifo_wr_arbiter;

   localparam int DW = 8;
   localparam int NR = 4;
   localparam int MB = 4;
   localparam int IW = 2;

   logic               wr_clk = 1'b0;
   logic               wr_rst_n;
   logic [NR-1:0]      req_valid, req_last, req_ready;
   logic [NR*DW-1:0]   req_data;
   logic               fifo_full;
   logic               fifo_wr_en;
   logic [DW-1:0]      fifo_wr_data;
   logic [IW-1:0]      grant_id;
   logic               busy;

   always #5 wr_clk = ~wr_clk;

   fifo_wr_arbiter #(
      .DATA_WIDTH (DW),
      .NUM_REQ    (NR),
      .MAX_BURST  (MB)
   ) dut (
      .wr_clk       (wr_clk),
      .wr_rst_n     (wr_rst_n),
      .req_valid    (req_valid),
      .req_data     (req_data),
      .req_last     (req_last),
      .req_ready    (req_ready),
      .fifo_full    (fifo_full),
      .fifo_wr_en   (fifo_wr_en),
      .fifo_wr_data (fifo_wr_data),
      .grant_id     (grant_id),
      .busy         (busy)
   );

   int total = 0;
   int bad   = 0;

   // Per-requester beat sources.
   logic [DW-1:0] src_data [NR][32];
   logic          src_last [NR][32];
   int            head [NR];
   int            tail [NR];
   logic [NR-1:0] hold;

   // Behavioural model of the arbiter.
   logic m_busy;
   int   m_gid, m_cnt, m_last;

   // Observed writes.
   logic [DW-1:0] wlog_data [64];
   int            wlog_gid  [64];
   int            wlog_cyc  [64];
   int            nw, cyc;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push(input int r, input logic [DW-1:0] d, input logic l);
      src_data[r][tail[r]] = d;
      src_last[r][tail[r]] = l;
      tail[r]++;
   endtask

   task automatic apply_inputs();
      for (int i = 0; i < NR; i++) begin
         if (head[i] < tail[i]) begin
            req_valid[i]           = !hold[i];
            req_last[i]            = src_last[i][head[i]];
            req_data[i*DW +: DW]   = src_data[i][head[i]];
         end else begin
            req_valid[i]           = 1'b0;
            req_last[i]            = 1'b0;
            req_data[i*DW +: DW]   = '0;
         end
      end
   endtask

   task automatic model_reset();
      m_busy = 1'b0;
      m_gid  = 0;
      m_cnt  = 0;
      m_last = NR - 1;
      cyc    = 0;
      nw     = 0;
   endtask

   task automatic clear_sources();
      for (int i = 0; i < NR; i++) begin
         head[i] = 0;
         tail[i] = 0;
      end
      hold      = '0;
      fifo_full = 1'b0;
   endtask

   task automatic reset_dut();
      wr_rst_n = 1'b0;
      clear_sources();
      apply_inputs();
      #1;
      chk("rst_busy", 32'(busy), 32'(0));
      chk("rst_grant_id", 32'(grant_id), 32'(0));
      chk("rst_wr_en", 32'(fifo_wr_en), 32'(0));
      chk("rst_ready", 32'(req_ready), 32'(0));
      repeat (2) @(posedge wr_clk);
      #1;
      wr_rst_n = 1'b1;
      model_reset();
   endtask

   // One clock: compare at the falling edge, advance the model at the rising edge.
   task automatic cycle();
      logic [NR-1:0] e_ready;
      logic          e_wr;
      logic          fin;
      int            idx;
      @(negedge wr_clk);
      cyc++;
      if (!m_busy) begin
         e_ready = '0;
         e_wr    = 1'b0;
      end else begin
         e_ready = fifo_full ? '0 : (NR'(1) << m_gid);
         e_wr    = req_valid[m_gid] && !fifo_full;
      end
      chk("busy", 32'(busy), 32'(m_busy));
      chk("grant_id", 32'(grant_id), 32'(m_gid));
      chk("req_ready", 32'(req_ready), 32'(e_ready));
      chk("fifo_wr_en", 32'(fifo_wr_en), 32'(e_wr));
      if (e_wr) chk("fifo_wr_data", 32'(fifo_wr_data), 32'(src_data[m_gid][head[m_gid]]));
      if (fifo_wr_en === 1'b1 && nw < 64) begin
         wlog_data[nw] = fifo_wr_data;
         wlog_gid[nw]  = int'(grant_id);
         wlog_cyc[nw]  = cyc;
         nw++;
      end
      @(posedge wr_clk);
      if (!m_busy) begin
         if (|req_valid) begin
            for (int k = 1; k <= NR; k++) begin
               idx = (m_last + k) % NR;
               if (req_valid[idx]) begin
                  m_gid = idx;
                  break;
               end
            end
            m_busy = 1'b1;
         end
      end else if (req_valid[m_gid] && !fifo_full) begin
         fin = src_last[m_gid][head[m_gid]];
         head[m_gid]++;
         m_cnt++;
         if (fin || m_cnt == MB) begin
            m_busy = 1'b0;
            m_last = m_gid;
            m_gid  = 0;
            m_cnt  = 0;
         end
      end
      #1;
      apply_inputs();
   endtask

   initial begin
      wr_rst_n  = 1'b0;
      req_valid = '0;
      req_last  = '0;
      req_data  = '0;
      fifo_full = 1'b0;

      // Two 3-beat packets from requesters 0 and 2.
      reset_dut();
      for (int b = 0; b < 3; b++) begin
         push(0, 8'h10 + 8'(b), b == 2);
         push(2, 8'h30 + 8'(b), b == 2);
      end
      apply_inputs();
      repeat (10) cycle();
      chk("t1_nw", 32'(nw), 32'(6));
      chk("t1_first_cyc", 32'(wlog_cyc[0]), 32'(2));
      chk("t1_r0_end_cyc", 32'(wlog_cyc[2]), 32'(4));
      chk("t1_r2_start_cyc", 32'(wlog_cyc[3]), 32'(6));
      chk("t1_r2_gid", 32'(wlog_gid[3]), 32'(2));
      chk("t1_data2", 32'(wlog_data[2]), 32'h12);
      chk("t1_data5", 32'(wlog_data[5]), 32'h32);

      // All four requesters with single-beat packets.
      reset_dut();
      for (int r = 0; r < NR; r++) begin
         push(r, 8'h40 + 8'(r), 1'b1);
         push(r, 8'h50 + 8'(r), 1'b1);
      end
      apply_inputs();
      repeat (10) cycle();
      for (int k = 0; k < 5; k++) begin
         chk("t2_gid", 32'(wlog_gid[k]), 32'(k % NR));
         chk("t2_cyc", 32'(wlog_cyc[k]), 32'(2 + 2 * k));
      end
      chk("t2_data4", 32'(wlog_data[4]), 32'h50);

      // Last beat presented while the FIFO is full.
      reset_dut();
      push(0, 8'h50, 1'b0);
      push(0, 8'h51, 1'b1);
      apply_inputs();
      repeat (2) cycle();
      fifo_full = 1'b1;
      repeat (5) cycle();
      chk("t3_nw_full", 32'(nw), 32'(1));
      chk("t3_busy_full", 32'(busy), 32'(1));
      fifo_full = 1'b0;
      repeat (2) cycle();
      chk("t3_nw", 32'(nw), 32'(2));
      chk("t3_cyc", 32'(wlog_cyc[1]), 32'(8));
      chk("t3_data", 32'(wlog_data[1]), 32'h51);

      // Forced release at MAX_BURST, then re-compete.
      reset_dut();
      for (int b = 0; b < 10; b++) push(1, 8'h60 + 8'(b), 1'b0);
      push(3, 8'h90, 1'b1);
      apply_inputs();
      repeat (14) cycle();
      chk("t4_burst_end", 32'(wlog_data[3]), 32'h63);
      chk("t4_gid3", 32'(wlog_gid[4]), 32'(3));
      chk("t4_data3", 32'(wlog_data[4]), 32'h90);
      chk("t4_resume_gid", 32'(wlog_gid[5]), 32'(1));
      chk("t4_resume_data", 32'(wlog_data[5]), 32'h64);
      chk("t4_resume_cyc", 32'(wlog_cyc[5]), 32'(9));

      // Holder gaps mid-packet while requester 2 waits.
      reset_dut();
      push(0, 8'hA0, 1'b0);
      push(0, 8'hA1, 1'b0);
      push(0, 8'hA2, 1'b1);
      push(2, 8'hB0, 1'b1);
      apply_inputs();
      repeat (2) cycle();
      hold[0] = 1'b1;
      apply_inputs();
      repeat (3) cycle();
      chk("t5_nw_gap", 32'(nw), 32'(1));
      chk("t5_gid_gap", 32'(grant_id), 32'(0));
      hold[0] = 1'b0;
      apply_inputs();
      repeat (4) cycle();
      chk("t5_gid2", 32'(wlog_gid[3]), 32'(2));
      chk("t5_cyc2", 32'(wlog_cyc[3]), 32'(9));

      // Asynchronous reset mid-packet.
      reset_dut();
      for (int b = 0; b < 4; b++) push(1, 8'hC0 + 8'(b), b == 3);
      apply_inputs();
      repeat (3) cycle();
      #2;
      wr_rst_n = 1'b0;
      #1;
      chk("t6_wr_en_async", 32'(fifo_wr_en), 32'(0));
      chk("t6_busy_async", 32'(busy), 32'(0));
      chk("t6_gid_async", 32'(grant_id), 32'(0));
      @(posedge wr_clk);
      #1;
      wr_rst_n = 1'b1;
      model_reset();
      push(0, 8'hD0, 1'b1);
      apply_inputs();
      repeat (6) cycle();
      chk("t6_first_gid", 32'(wlog_gid[0]), 32'(0));
      chk("t6_first_data", 32'(wlog_data[0]), 32'hD0);
      chk("t6_resume_data", 32'(wlog_data[1]), 32'hC2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
